uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CLK_FREQUENCY, default 12_000_000, system clock in Hz.
REQ-002 Parameter BAUD, default 115_200, serial line rate.
REQ-003 Parameter MAX_LEN, default 16, maximum payload bytes per frame.
REQ-004 Parameter TIMEOUT_BYTES, default 4, inter-byte timeout expressed in character times (10 bits each).
REQ-005 clk_12mhz  input  1  system clock; all logic on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 rx_data  input  8  byte from upstream UART receiver.
REQ-008 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 tx_busy  input  1  downstream UART transmitter busy; high from the cycle after tx_start until the stop bit completes.
REQ-010 tx_data  output  8  byte to transmit; held stable while tx_start is high.
REQ-011 tx_start  output  1  one-cycle request to transmit tx_data.
REQ-012 led  output  8  last value written by the LED command.
REQ-013 frame_err  output  1  one-cycle pulse on any rejected or timed-out frame.

Function
REQ-014 Frame format SHALL be: SOH 0x01, CMD, LEN, LEN payload bytes, CSUM; CSUM is the XOR of CMD, LEN and all payload bytes.
REQ-015 States SHALL be IDLE, CMD, LEN, PAYLOAD, CSUM, RESP, TX_WAIT.
REQ-016 In IDLE, a received byte other than 0x01 SHALL be discarded; 0x01 -> CMD.
REQ-017 CMD: store byte and initialise checksum to it -> LEN.
REQ-018 LEN: if LEN > MAX_LEN, queue NAK 0x15, pulse frame_err -> RESP; if LEN = 0 -> CSUM; else -> PAYLOAD.
REQ-019 PAYLOAD: write each byte to the buffer at the index given by a counter, XOR it into the checksum, and go to CSUM after the LEN-th byte.
REQ-020 CSUM: on mismatch queue NAK 0x15 and pulse frame_err; on match decode CMD.
REQ-021 CMD 0x10 (echo) SHALL queue the response 0x06, CMD, then payload bytes 0..LEN-1 in order.
REQ-022 CMD 0x20 (LED) with LEN >= 1 SHALL load led with payload[0] in the CSUM-accept cycle and queue the response 0x06, 0x20.
REQ-023 Any other CMD, or 0x20 with LEN = 0, SHALL queue NAK 0x15 and pulse frame_err; led is unchanged.
REQ-024 RESP: when tx_busy = 0, drive the next response byte and pulse tx_start for one cycle -> TX_WAIT.
REQ-025 TX_WAIT: ignore tx_busy for the first cycle, then wait for tx_busy = 0; -> RESP if bytes remain, else IDLE.
REQ-026 Response latency: tx_start SHALL rise no later than 2 cycles after the CSUM (or rejecting LEN) rx_valid when tx_busy = 0.
REQ-027 Bytes arriving in RESP/TX_WAIT SHALL be dropped without state change.
REQ-028 Timeout counter SHALL clear on every rx_valid and count only in CMD, LEN, PAYLOAD and CSUM.
REQ-029 On reaching TIMEOUT_BYTES*10*CLK_FREQUENCY/BAUD cycles (4166 at defaults), the block SHALL pulse frame_err and return to IDLE with no response.
REQ-030 If rx_valid and the timeout terminal count occur in the same cycle, rx_valid SHALL win and the counter clears.
REQ-031 Checksum and payload index widths SHALL be 8 bits and clog2(MAX_LEN+1) bits; the index never wraps because LEN is bounded by REQ-018.

Reset
REQ-032 Reset SHALL force state IDLE, tx_start = 0, tx_data = 0x00, led = 0x00, frame_err = 0, and all counters and the checksum to 0, including mid-frame and mid-response; no tx_start is issued after a reset until a new frame completes.
REQ-033 Payload buffer contents need not be reset.

Structure
REQ-034 SOH, ACK, NAK, command codes and state encodings SHALL live in a shared package (uart_cmd_pkg).
REQ-035 A single sub-module, uart_cmd_timeout (parameterised down-counter with clear, enable and terminal pulse), SHALL implement REQ-028..030.

Verification
REQ-036 Bytes 01 10 02 AA BB 03 -> tx bytes 06 10 AA BB in order, one tx_start each; frame_err never pulses.
REQ-037 Bytes 01 20 01 5A 7B -> led = 0x5A; tx 06 20.
REQ-038 Bytes 01 20 01 5A 00 (bad CSUM) -> tx 15, one frame_err pulse, led unchanged; unknown CMD 01 33 00 33 -> tx 15.
REQ-039 Bytes 01 10 11 (LEN = 17) -> tx 15 immediately; the following bytes 55 66 are ignored in IDLE.
REQ-040 Bytes 01 10, then idle for 4200 cycles -> frame_err pulse, no tx_start; a following valid echo frame is answered correctly.
REQ-041 Assert reset_n = 0 during transmission of the second echo response byte -> all outputs take their reset values in the next cycle, no further tx_start occurs, and the stray bytes AA BB are ignored.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] CMD_ECHO = 8'h10;
  localparam logic [7:0] CMD_LED  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_RESP,
    ST_TX_WAIT
  } state_e;

  // States in which a frame is being received and the inter-byte timer runs.
  function automatic logic is_frame_state(input state_e s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: down-counter reloaded on clear, terminal pulse when it
// runs out while enabled. Clear has priority over the terminal pulse.
module uart_cmd_timeout #(
  parameter int unsigned COUNT = 4166
) (
  input  logic clk_12mhz,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(COUNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_c = 1'b0;
    if (clr_i) begin
      cnt_d = CW'(COUNT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d    = cnt_q - CW'(1);
      expire_c = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser: SOH CMD LEN payload CSUM in, ACK/NAK responses out
// through a byte-wide UART transmitter handshake.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 12_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] led,
  output logic       frame_err
);

  localparam longint unsigned TMO_L =
    (64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQUENCY)) / 64'(BAUD);
  localparam int unsigned TMO_CYCLES = 32'(TMO_L);
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned RW = $clog2(MAX_LEN + 3);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      led_q, led_d;
  logic            frame_err_q, frame_err_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      resp_hdr_q, resp_hdr_d;
  logic [RW-1:0]   resp_len_q, resp_len_d;
  logic [RW-1:0]   resp_idx_q, resp_idx_d;
  logic            first_q, first_d;

  logic [7:0]      pay_q [MAX_LEN];
  logic            pay_we_c;
  logic [AW-1:0]   pl_idx_c;
  logic [7:0]      resp_byte_c;
  logic            tmo_expire_c;

  uart_cmd_timeout #(
    .COUNT (TMO_CYCLES)
  ) u_timeout (
    .clk_12mhz (clk_12mhz),
    .reset_n   (reset_n),
    .clr_i     (rx_valid),
    .en_i      (is_frame_state(state_q)),
    .expire_c  (tmo_expire_c)
  );

  // Response byte stream: header, command echo, then buffered payload.
  always_comb begin
    pl_idx_c = AW'(resp_idx_q - RW'(2));
    if (resp_idx_q == '0)          resp_byte_c = resp_hdr_q;
    else if (resp_idx_q == RW'(1)) resp_byte_c = cmd_q;
    else                           resp_byte_c = pay_q[pl_idx_c];
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    led_d       = led_q;
    frame_err_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    resp_hdr_d  = resp_hdr_q;
    resp_len_d  = resp_len_q;
    resp_idx_d  = resp_idx_q;
    first_d     = 1'b0;
    pay_we_c    = 1'b0;

    if (tmo_expire_c) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SOH)) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (rx_valid) begin
            cmd_d   = rx_data;
            csum_d  = rx_data;
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            csum_d = csum_q ^ rx_data;
            idx_d  = '0;
            if (32'(rx_data) > MAX_LEN) begin
              resp_hdr_d  = NAK;
              resp_len_d  = RW'(1);
              resp_idx_d  = '0;
              frame_err_d = 1'b1;
              state_d     = ST_RESP;
            end else begin
              len_d   = IW'(rx_data);
              state_d = (rx_data == 8'h00) ? ST_CSUM : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            pay_we_c = 1'b1;
            csum_d   = csum_q ^ rx_data;
            idx_d    = idx_q + IW'(1);
            if (idx_q == len_q - IW'(1)) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            resp_idx_d  = '0;
            resp_hdr_d  = NAK;
            resp_len_d  = RW'(1);
            state_d     = ST_RESP;
            if (rx_data != csum_q) begin
              frame_err_d = 1'b1;
            end else if (cmd_q == CMD_ECHO) begin
              resp_hdr_d = ACK;
              resp_len_d = RW'(len_q) + RW'(2);
            end else if ((cmd_q == CMD_LED) && (len_q != '0)) begin
              led_d      = pay_q[0];
              resp_hdr_d = ACK;
              resp_len_d = RW'(2);
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (!tx_busy) begin
            tx_data_d  = resp_byte_c;
            tx_start_d = 1'b1;
            resp_idx_d = resp_idx_q + RW'(1);
            first_d    = 1'b1;
            state_d    = ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // tx_busy only becomes meaningful one cycle after tx_start.
          if (!first_q && !tx_busy) begin
            state_d = (resp_idx_q == resp_len_q) ? ST_IDLE : ST_RESP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      led_q       <= '0;
      frame_err_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      resp_hdr_q  <= '0;
      resp_len_q  <= '0;
      resp_idx_q  <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      led_q       <= led_d;
      frame_err_q <= frame_err_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      resp_hdr_q  <= resp_hdr_d;
      resp_len_q  <= resp_len_d;
      resp_idx_q  <= resp_idx_d;
      first_q     <= first_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk_12mhz) begin
    if (pay_we_c) pay_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign led       = led_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a simple transmitter busy model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  logic       clk_12mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] led;
  logic       frame_err;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         busy_cnt = 0;
  int         err_cnt  = 0;
  logic [7:0] tx_log [$];

  uart_cmd_parser dut (
    .clk_12mhz (clk_12mhz),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .led       (led),
    .frame_err (frame_err)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  assign tx_busy = (busy_cnt != 0);

  // Transmitter model: busy for 20 cycles after each tx_start; logs bytes and error pulses.
  always @(posedge clk_12mhz) begin
    if (tx_start) begin
      busy_cnt <= 20;
      tx_log.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_12mhz);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_12mhz);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr [$]);
    foreach (fr[i]) begin
      send(fr[i]);
      if (i != fr.size() - 1) tick(2);
    end
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp [$],
                           input int base, input int err_base, input int exp_err);
    int t;
    t = 0;
    while ((tx_log.size() - base < exp.size()) && (t < 2000)) begin
      tick(1);
      t++;
    end
    tick(60);
    chk($sformatf("%s_count", tag), 32'(tx_log.size() - base), 32'(exp.size()));
    foreach (exp[i]) begin
      if (base + i < tx_log.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(tx_log[base + i]), 32'(exp[i]));
    end
    chk($sformatf("%s_err", tag), 32'(err_cnt - err_base), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] fr [$];
    logic [7:0] ex [$];
    logic [7:0] cs;
    int b, e, t;

    tick(4);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Echo with two payload bytes, plus response latency
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h03};
    send_frame(fr);
    tick(1);
    chk("echo_latency", 32'(tx_start), 32'd1);
    ex = '{8'h06, 8'h10, 8'hAA, 8'hBB};
    expect_tx("echo", ex, b, e, 0);

    // Echo with LEN = 0
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h00, 8'h10};
    send_frame(fr);
    ex = '{8'h06, 8'h10};
    expect_tx("echo0", ex, b, e, 0);

    // Echo with LEN = MAX_LEN
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h10};
    ex = '{8'h06, 8'h10};
    cs = 8'h10 ^ 8'h10;
    for (int i = 0; i < 16; i++) begin
      fr.push_back(8'(i * 7 + 3));
      ex.push_back(8'(i * 7 + 3));
      cs = cs ^ 8'(i * 7 + 3);
    end
    fr.push_back(cs);
    send_frame(fr);
    expect_tx("echo16", ex, b, e, 0);

    // LED command
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h20, 8'h01, 8'h5A, 8'h7B};
    send_frame(fr);
    ex = '{8'h06, 8'h20};
    expect_tx("led", ex, b, e, 0);
    chk("led_value", 32'(led), 32'h5A);

    // LED command with bad checksum
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h20, 8'h01, 8'hA5, 8'h00};
    send_frame(fr);
    ex = '{8'h15};
    expect_tx("badcsum", ex, b, e, 1);
    chk("badcsum_led", 32'(led), 32'h5A);

    // Unknown command
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h33, 8'h00, 8'h33};
    send_frame(fr);
    ex = '{8'h15};
    expect_tx("unknown", ex, b, e, 1);

    // LED with LEN = 0 is rejected, led untouched
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h20, 8'h00, 8'h20};
    send_frame(fr);
    ex = '{8'h15};
    expect_tx("led0", ex, b, e, 1);
    chk("led0_led", 32'(led), 32'h5A);

    // LEN = 17 rejected right after the LEN byte
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h11};
    send_frame(fr);
    tick(1);
    chk("len17_latency", 32'(tx_start), 32'd1);
    ex = '{8'h15};
    expect_tx("len17", ex, b, e, 1);
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h55, 8'h66};
    send_frame(fr);
    ex = {};
    expect_tx("len17_tail", ex, b, e, 0);

    // Inter-byte timeout after CMD
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10};
    send_frame(fr);
    tick(4100);
    chk("tmo_early", 32'(err_cnt - e), 32'd0);
    tick(100);
    chk("tmo_err", 32'(err_cnt - e), 32'd1);
    chk("tmo_no_tx", 32'(tx_log.size() - b), 32'd0);

    // Recovery after timeout
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h01, 8'hC3, 8'hD2};
    send_frame(fr);
    ex = '{8'h06, 8'h10, 8'hC3};
    expect_tx("post_tmo", ex, b, e, 0);

    // Reset during the second echo response byte
    b = tx_log.size(); e = err_cnt;
    fr = '{8'h01, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h03};
    send_frame(fr);
    t = 0;
    while ((tx_log.size() - b < 2) && (t < 2000)) begin
      tick(1);
      t++;
    end
    chk("rst_mid_reached", 32'(tx_log.size() - b), 32'd2);
    reset_n = 1'b0;
    tick(1);
    chk("rst_mid_tx_start", 32'(tx_start), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'h00);
    chk("rst_mid_led", 32'(led), 32'h00);
    chk("rst_mid_frame_err", 32'(frame_err), 32'd0);
    tick(3);
    reset_n = 1'b1;
    fr = '{8'hAA, 8'hBB};
    send_frame(fr);
    tick(300);
    chk("rst_mid_no_tx", 32'(tx_log.size() - b), 32'd2);
    chk("rst_mid_no_err", 32'(err_cnt - e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
